wb_pwm: RTL
===========

# wb_pwm

Wishbone slave peripheral driving two PWM outputs and two direction lines, e.g. for the robot's motor drivers. It is the output-side counterpart to the push-button input peripheral on the same bus. The CPU writes the period, duty and control registers. A free-running 16-bit counter generates edge-aligned PWM. Period and duty updates are double-buffered so they only take effect at period boundaries. A period-wrap interrupt is provided for motor-control loops.

## Interface
- `CNT_W`, default 16: counter, period and duty width.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-low reset.
- `wb_stb_i` in 1: Wishbone strobe.
- `wb_cyc_i` in 1: Wishbone cycle.
- `wb_ack_o` out 1: Wishbone acknowledge.
- `wb_we_i` in 1: write enable.
- `wb_adr_i` in 32: byte address. Only `[7:0]` is decoded.
- `wb_sel_i` in 4: byte select. Ignored; all accesses are full-word.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data. Registered.
- `intr` out 1: level interrupt, high when `STATUS.wrap & CTRL.ie`.
- `pwm_o` out 2: PWM outputs, channel 0 is bit 0. Registered.
- `dir_o` out 2: direction outputs. Equal to `CTRL[3:2]`.

## Operation
- Register map (offset, access, fields):
  - 0x00 `CTRL` (R/W): `[0]` en0, `[1]` en1, `[2]` dir0, `[3]` dir1, `[4]` ie. Other bits read 0.
  - 0x04 `PERIOD` (R/W): `[CNT_W-1:0]` = TOP. The counter counts 0..TOP, so the period is TOP+1 cycles.
  - 0x08 `DUTY0` (R/W) and 0x0C `DUTY1` (R/W): `[CNT_W-1:0]` = high time in cycles.
  - 0x10 `STATUS`: `[0]` wrap, sticky. Writing 1 to bit 0 clears it.
  - Any other offset reads 0; writes to it are ignored.
- Reads of `PERIOD` and `DUTYx` return the pending (written) value, not the active value.
- Counter behaviour:
  - Runs when en0 | en1.
  - While both enables are 0, the counter is held at 0 and the active registers track the pending registers every cycle.
  - At `cnt == TOP_act`: next `cnt` = 0, `TOP_act` <= `PERIOD`, `DUTYx_act` <= `DUTYx`, and `STATUS.wrap` is set.
- Channel output: `pwm_o[i] <= en_i & (cnt < DUTYi_act)`.
  - DUTY = 0 gives constant low.
  - DUTY > TOP gives constant high.
- Boundary cases:
  - TOP = 0: wrap every cycle; output is high iff DUTY ≥ 1.
  - A wrap set and a STATUS clear-write in the same cycle: set wins, flag stays 1.
  - A write to `PERIOD` or `DUTYx` in the same cycle as a wrap: the newly written value is the one loaded.
  - Clearing an enable forces that `pwm_o` bit low on the next edge, regardless of phase.
  - Reset asserted mid-period: everything returns to reset values on the next edge.
- Reset values: all registers 0, `cnt` 0, `pwm_o` 0, `dir_o` 0, `intr` 0, `ack` 0, `wb_dat_o` 0.

## Timing
- Wishbone handshake:
  - `wb_ack_o = wb_stb_i & wb_cyc_i & ack`.
  - `ack` pulses for one cycle, set on the edge after `stb & cyc & ~ack` is seen.
  - Back-to-back accesses take 2 cycles each.
  - A dropped strobe aborts the access with no side effect.
- Writes update the register on the same edge that raises `ack`.
- Read data is registered on that same edge and is valid while `wb_ack_o` is high.
- `pwm_o` lags the counter compare by 1 cycle.
- `CTRL` changes reach `dir_o` and `intr` 1 cycle after the ack edge.
- `intr` rises the cycle after the wrap edge.

## Configuration
- `WB_PWM_SHADOW_EN` defined: double-buffering as described; active values load only at a wrap or while the counter is idle.
- `WB_PWM_SHADOW_EN` undefined: `TOP_act` and `DUTYx_act` are the written registers directly, so writes take effect on the next compare. If a write lowers TOP below the current `cnt`, the counter runs to its max value and wraps through 0.

## Structure
- Package `wb_pwm_pkg` holds:
  - register offset constants `ADR_CTRL`, `ADR_PERIOD`, `ADR_DUTY0`, `ADR_DUTY1`, `ADR_STATUS`;
  - `CTRL` bit index constants;
  - the default `CNT_W`.
- Sub-module `pwm_channel`, instantiated twice: holds the active duty register, the shadow load, the compare and the registered output. The counter and bus logic live in `wb_pwm`.

## Test plan
- Reset, then read all five offsets → all 0. `pwm_o` = 0, `dir_o` = 0, `intr` = 0.
- PERIOD = 9, DUTY0 = 3, CTRL = 0x1 → `pwm_o[0]` is 3 cycles high, 7 low, repeating every 10 cycles. `pwm_o[1]` stays 0.
- While running, write DUTY0 = 7 mid-period → the current period keeps 3 high cycles; the next period has 7 high cycles. Readback returns 7 immediately.
- DUTY1 = 0 then DUTY1 = 20 with PERIOD = 9, CTRL = 0x2 → `pwm_o[1]` is constant 0, then constant 1 after the next wrap.
- CTRL = 0x13 → `intr` rises 1 cycle after each wrap. Writing 1 to STATUS clears it. A clear coinciding with a wrap leaves `intr` = 1.
- Assert reset mid-period, and separately perform an access with the strobe dropped before ack → outputs go to 0 on the next edge; the aborted write leaves the register unchanged.

Source files
------------

// File: rtl/wb_pwm_pkg.sv
// Shared constants for the wb_pwm Wishbone PWM peripheral: register offsets,
// CTRL bit positions and the default counter width.
package wb_pwm_pkg;

  localparam int unsigned DEF_CNT_W = 16;

  localparam logic [7:0] ADR_CTRL   = 8'h00;
  localparam logic [7:0] ADR_PERIOD = 8'h04;
  localparam logic [7:0] ADR_DUTY0  = 8'h08;
  localparam logic [7:0] ADR_DUTY1  = 8'h0C;
  localparam logic [7:0] ADR_STATUS = 8'h10;

  localparam int unsigned CTRL_EN0  = 0;
  localparam int unsigned CTRL_EN1  = 1;
  localparam int unsigned CTRL_DIR0 = 2;
  localparam int unsigned CTRL_DIR1 = 3;
  localparam int unsigned CTRL_IE   = 4;
  localparam int unsigned CTRL_W    = 5;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, compare against the shared counter
// and registered output. WB_PWM_SHADOW_EN selects double-buffered duty.
module pwm_channel
  import wb_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] duty_nxt,
  input  logic [CNT_W-1:0] duty_cur,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm_o
);

  logic [CNT_W-1:0] duty_act;
  logic             pwm_q, pwm_d;

`ifdef WB_PWM_SHADOW_EN
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             unused_cur;

  assign unused_cur = ^duty_cur;

  always_comb begin
    duty_act_d = load ? duty_nxt : duty_act_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) duty_act_q <= '0;
    else        duty_act_q <= duty_act_d;
  end

  assign duty_act = duty_act_q;
`else
  logic unused_shadow;

  assign unused_shadow = ^{load, duty_nxt};
  assign duty_act      = duty_cur;
`endif

  always_comb begin
    pwm_d = en & (cnt < duty_act);
  end

  always_ff @(posedge clk) begin
    if (!reset) pwm_q <= 1'b0;
    else        pwm_q <= pwm_d;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/wb_pwm.sv
// Wishbone slave with two edge-aligned PWM channels, direction lines and a
// period-wrap interrupt. WB_PWM_SHADOW_EN enables period/duty double-buffering.
module wb_pwm
  import wb_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        intr,
  output logic [1:0]  pwm_o,
  output logic [1:0]  dir_o
);

  logic              ack_q, ack_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  duty0_q, duty0_d;
  logic [CNT_W-1:0]  duty1_q, duty1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  top_act;
  logic [7:0]        adr;
  logic              access, wr, run, at_top, load;
  logic              unused_bus;

  assign adr        = wb_adr_i[7:0];
  assign unused_bus = ^{wb_adr_i[31:8], wb_sel_i, wb_dat_i};

  assign access = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr     = access & wb_we_i;
  assign run    = ctrl_q[CTRL_EN0] | ctrl_q[CTRL_EN1];
  assign at_top = run & (cnt_q == top_act);
  // Active registers reload from the value being written this cycle, if any.
  assign load   = ~run | at_top;

  always_comb begin
    ack_d    = access;
    ctrl_d   = ctrl_q;
    period_d = period_q;
    duty0_d  = duty0_q;
    duty1_d  = duty1_q;
    wrap_d   = wrap_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q + 1'b1;

    if (wr) begin
      case (adr)
        ADR_CTRL:   ctrl_d   = wb_dat_i[CTRL_W-1:0];
        ADR_PERIOD: period_d = wb_dat_i[CNT_W-1:0];
        ADR_DUTY0:  duty0_d  = wb_dat_i[CNT_W-1:0];
        ADR_DUTY1:  duty1_d  = wb_dat_i[CNT_W-1:0];
        ADR_STATUS: if (wb_dat_i[0]) wrap_d = 1'b0;
        default: ;
      endcase
    end
    if (at_top) wrap_d = 1'b1;

    if (access & ~wb_we_i) begin
      rdata_d = '0;
      case (adr)
        ADR_CTRL:   rdata_d[CTRL_W-1:0] = ctrl_q;
        ADR_PERIOD: rdata_d[CNT_W-1:0]  = period_q;
        ADR_DUTY0:  rdata_d[CNT_W-1:0]  = duty0_q;
        ADR_DUTY1:  rdata_d[CNT_W-1:0]  = duty1_q;
        ADR_STATUS: rdata_d[0]          = wrap_q;
        default: ;
      endcase
    end

    if (load) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_q    <= 1'b0;
      ctrl_q   <= '0;
      period_q <= '0;
      duty0_q  <= '0;
      duty1_q  <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      duty0_q  <= duty0_d;
      duty1_q  <= duty1_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef WB_PWM_SHADOW_EN
  logic [CNT_W-1:0] top_act_q, top_act_d;

  always_comb begin
    top_act_d = load ? period_d : top_act_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) top_act_q <= '0;
    else        top_act_q <= top_act_d;
  end

  assign top_act = top_act_q;
`else
  // Lowering TOP below cnt lets the counter roll over through its max value.
  assign top_act = period_q;
`endif

  pwm_channel #(.CNT_W(CNT_W)) u_ch0 (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl_q[CTRL_EN0]),
    .load     (load),
    .duty_nxt (duty0_d),
    .duty_cur (duty0_q),
    .cnt      (cnt_q),
    .pwm_o    (pwm_o[0])
  );

  pwm_channel #(.CNT_W(CNT_W)) u_ch1 (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl_q[CTRL_EN1]),
    .load     (load),
    .duty_nxt (duty1_d),
    .duty_cur (duty1_q),
    .cnt      (cnt_q),
    .pwm_o    (pwm_o[1])
  );

  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = rdata_q;
  assign dir_o    = ctrl_q[CTRL_DIR1:CTRL_DIR0];
  assign intr     = wrap_q & ctrl_q[CTRL_IE];

endmodule
